// File: rtl/el2_pkg.sv
// Shared types for the EL2 lockstep error-handling path.
// Provides the handler FSM state encoding and a small constant helper.
package el2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALERT,
      ACK_LOW,
      RESET,
      LOCKED
   } el2_lse_state_e;

   function automatic int el2_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/el2_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Latency: count reflects clr/inc one cycle after they are sampled.
// Backpressure: none; increments past all-ones are absorbed.
module el2_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] count_d;

   // Clear first, so a same-cycle increment lands on zero.
   always_comb begin
      base    = clr ? '0 : count;
      count_d = base;
      if (inc && (base != {WIDTH{1'b1}})) begin
         count_d = base + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count_d;
      end
   end

endmodule

// File: rtl/el2_lockstep_err_handler.sv
// Counts lockstep mismatches, runs a four-phase alert handshake, escalates to core reset + lock.
// Latency: all outputs registered, one cycle after the triggering input edge.
// Backpressure: alert waits on alert_ack_i up to ACK_TIMEOUT cycles, then escalates on its own.
module el2_lockstep_err_handler
   import el2_pkg::*;
#(
   parameter int ERR_CNT_W     = 8,
   parameter int ESC_THRESHOLD = 4,
   parameter int ACK_TIMEOUT   = 16,
   parameter int RST_PULSE_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 corruption_detected_i,
   input  logic                 disable_corruption_detection_i,
   input  logic                 clear_i,
   input  logic                 alert_ack_i,
   output logic                 alert_req_o,
   output logic [ERR_CNT_W-1:0] err_count_o,
   output logic                 err_sticky_o,
   output logic                 alert_timeout_o,
   output logic                 core_rst_req_o,
   output logic                 escalate_o
);

   localparam int TMR_MAX = el2_max(ACK_TIMEOUT, RST_PULSE_LEN);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RST_PULSE_LEN - 1);
   localparam logic [31:0]      ESC_THR  = ESC_THRESHOLD;

   el2_lse_state_e   state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             evt, evt_q, new_err;
   logic             clr_en;
   logic             pending_q, pending_d;
   logic             sticky_d, timeout_d;
   logic             at_threshold;

   assign evt          = corruption_detected_i & ~disable_corruption_detection_i;
   assign new_err      = evt & ~evt_q;
   assign clr_en       = clear_i & ((state_q == IDLE) | (state_q == LOCKED));
   assign at_threshold = 32'(err_count_o) >= ESC_THR;

   el2_sat_counter #(
      .WIDTH (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_en),
      .inc   (new_err),
      .count (err_count_o)
   );

   // One down-counter serves both the ack timeout and the reset pulse;
   // it is reloaded on entry to ALERT and RESET and expires at zero.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      pending_d = pending_q;
      sticky_d  = err_sticky_o;
      timeout_d = alert_timeout_o;

      if (clr_en) begin
         pending_d = 1'b0;
         sticky_d  = 1'b0;
         timeout_d = 1'b0;
      end
      if (new_err) begin
         sticky_d = 1'b1;
         if (state_q != IDLE) begin
            pending_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (new_err || (pending_q && !clr_en)) begin
               state_d   = ALERT;
               tmr_d     = ACK_LOAD;
               pending_d = 1'b0;
            end
         end
         ALERT: begin
            if (alert_ack_i) begin
               state_d = ACK_LOW;
            end else if (tmr_q == '0) begin
               state_d   = RESET;
               tmr_d     = RST_LOAD;
               timeout_d = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ACK_LOW: begin
            if (!alert_ack_i) begin
               if (at_threshold) begin
                  state_d = RESET;
                  tmr_d   = RST_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RESET: begin
            if (tmr_q == '0) begin
               state_d = LOCKED;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         LOCKED: begin
            if (clr_en) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         tmr_q           <= '0;
         evt_q           <= 1'b0;
         pending_q       <= 1'b0;
         err_sticky_o    <= 1'b0;
         alert_timeout_o <= 1'b0;
         alert_req_o     <= 1'b0;
         core_rst_req_o  <= 1'b0;
         escalate_o      <= 1'b0;
      end else begin
         state_q         <= state_d;
         tmr_q           <= tmr_d;
         evt_q           <= evt;
         pending_q       <= pending_d;
         err_sticky_o    <= sticky_d;
         alert_timeout_o <= timeout_d;
         alert_req_o     <= (state_d == ALERT);
         core_rst_req_o  <= (state_d == RESET);
         escalate_o      <= (state_d == LOCKED);
      end
   end

endmodule
